// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, radix constants, serial FSM states and
// a digit validity helper used by the BCD arithmetic blocks.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_MAX  = 9;
  localparam int BCD_BASE = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd_digit(input bcd_digit_t d);
    return (d <= bcd_digit_t'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtract with borrow: d = (a_d - b_d - borrow_in) mod 10.
// Purely combinational; shared across digits by the serial top level.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t i_a_d,
  input  bcd_digit_t i_b_d,
  input  logic       i_borrow_in,
  output bcd_digit_t o_d,
  output logic       o_borrow_out
);

  // 5-bit two's complement keeps the range -10..9 exact; bit 4 is the sign.
  logic [4:0] w_t;

  assign w_t          = {1'b0, i_a_d} - {1'b0, i_b_d} - {4'b0, i_borrow_in};
  assign o_borrow_out = w_t[4];
  assign o_d          = w_t[4] ? bcd_digit_t'(w_t[3:0] + 4'(BCD_BASE)) : w_t[3:0];

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Packed-BCD subtractor, A - B - bin, one digit per clock LSD first,
// with a start/done handshake and operand capture on start.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_a,
  input  logic [4*DIGITS-1:0]   i_b,
  input  logic                  i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_diff,
  output logic                  o_bout,
  output logic                  o_invalid
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

  state_t                   r_state, w_next;
  bcd_digit_t [DIGITS-1:0]  r_a, r_b, r_diff;
  bcd_digit_t [DIGITS-1:0]  w_a_in, w_b_in;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_borrow, r_bout, r_invalid;
  logic                     w_in_invalid;
  bcd_digit_t               w_d;
  logic                     w_borrow;

  assign w_a_in = i_a;
  assign w_b_in = i_b;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    w_in_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(w_a_in[i]) || !is_bcd_digit(w_b_in[i])) w_in_invalid = 1'b1;
    end
  end

  bcd_digit_sub u_digit_sub (
    .i_a_d        (r_a[r_idx]),
    .i_b_d        (r_b[r_idx]),
    .i_borrow_in  (r_borrow),
    .o_d          (w_d),
    .o_borrow_out (w_borrow)
  );

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = w_in_invalid ? DONE : RUN;
      RUN:     if (r_idx == LAST_IDX) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_diff    <= '0;
      r_idx     <= '0;
      r_borrow  <= 1'b0;
      r_bout    <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a       <= w_a_in;
            r_b       <= w_b_in;
            r_borrow  <= i_bin;
            r_idx     <= '0;
            r_diff    <= '0;
            r_bout    <= 1'b0;
            r_invalid <= w_in_invalid;
          end
        end
        RUN: begin
          r_diff[r_idx] <= w_d;
          r_borrow      <= w_borrow;
          if (r_idx == LAST_IDX) r_bout <= w_borrow;
          else                   r_idx  <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_busy    = (r_state != IDLE);
  assign o_done    = (r_state == DONE);
  assign o_diff    = r_diff;
  assign o_bout    = r_bout;
  assign o_invalid = r_invalid;

endmodule
